// File: rtl/memory_issue_queue.sv
// Memory issue queue: buffers load/store requests in a FIFO and issues
// them to memory as one or two line-aligned beats with byte enables.
// Ports: clock, reset (async active-low); req_valid/req_ready with
// load, store, address, store_data, log2_bytes; memory_valid/
// memory_ready with memory_read, memory_write, memory_byte_en,
// memory_address, memory_data, memory_last; issue_error,
// error_address, queue_count.
module memory_issue_queue #(
   parameter int DATA_WIDTH       = 32,
   parameter int ADDRESS_BITS     = 20,
   parameter int QUEUE_DEPTH      = 4,
   parameter bit SPLIT_MISALIGNED = 1'b1,
   localparam int NUM_BYTES       = DATA_WIDTH / 8,
   localparam int LOG2_NUM_BYTES  = $clog2(NUM_BYTES),
   localparam int CW              = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      load,
   input  logic                      store,
   input  logic [ADDRESS_BITS-1:0]   address,
   input  logic [DATA_WIDTH-1:0]     store_data,
   input  logic [LOG2_NUM_BYTES:0]   log2_bytes,
   output logic                      memory_valid,
   input  logic                      memory_ready,
   output logic                      memory_read,
   output logic                      memory_write,
   output logic [NUM_BYTES-1:0]      memory_byte_en,
   output logic [ADDRESS_BITS-1:0]   memory_address,
   output logic [DATA_WIDTH-1:0]     memory_data,
   output logic                      memory_last,
   output logic                      issue_error,
   output logic [ADDRESS_BITS-1:0]   error_address,
   output logic [CW-1:0]             queue_count
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int LB = LOG2_NUM_BYTES;
   localparam int NB = NUM_BYTES;
   localparam int DW = DATA_WIDTH;
   localparam int AB = ADDRESS_BITS;

   typedef struct packed {
      logic          load;
      logic          store;
      logic [AB-1:0] address;
      logic [DW-1:0] store_data;
      logic [LB:0]   log2_bytes;
   } entry_t;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   entry_t        slots [QUEUE_DEPTH];
   entry_t        head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   state_t        state;
   state_t        state_next;
   logic          enq;
   logic          deq;

   logic [LB-1:0]   off;
   logic [LB+1:0]   size;
   logic [LB+1:0]   span;
   logic            crossing;
   logic            illegal;
   logic [2*NB-1:0] mask;
   logic [2*NB-1:0] be_wide;
   logic [2*DW-1:0] data_wide;
   logic [AB-1:0]   aligned;

   // Gating with the reset input keeps req_ready low throughout reset
   assign req_ready   = reset && (count < CW'(QUEUE_DEPTH));
   assign enq         = req_valid && req_ready;
   assign queue_count = count;
   assign head        = slots[rd_ptr];

   always_ff @(posedge clock) begin
      if (enq)
         slots[wr_ptr] <= {load, store, address,
                           store_data, log2_bytes};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         state  <= IDLE;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         if (enq && !deq)
            count <= count + CW'(1);
         else if (!enq && deq)
            count <= count - CW'(1);
         state <= state_next;
      end
   end

   // Beat shaping: the access is shifted into a double-width window;
   // the low half is beat 0 and the high half is beat 1.
   assign off      = head.address[LB-1:0];
   assign size     = (LB+2)'(1) << head.log2_bytes;
   assign span     = {2'b00, off} + size;
   assign crossing = span > (LB+2)'(NB);
   assign illegal  = (head.log2_bytes > (LB+1)'(LB))
                  || (head.load == head.store)
                  || (crossing && !SPLIT_MISALIGNED);
   assign mask     = ((2*NB)'(1) << size) - (2*NB)'(1);
   assign be_wide  = mask << off;
   assign data_wide = {{DW{1'b0}}, head.store_data} << {off, 3'b000};
   assign aligned  = {head.address[AB-1:LB], {LB{1'b0}}};

   always_comb begin
      state_next     = state;
      deq            = 1'b0;
      issue_error    = 1'b0;
      error_address  = '0;
      memory_valid   = 1'b0;
      memory_read    = 1'b0;
      memory_write   = 1'b0;
      memory_byte_en = '0;
      memory_address = '0;
      memory_data    = '0;
      memory_last    = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               if (illegal) begin
                  deq           = 1'b1;
                  issue_error   = 1'b1;
                  error_address = head.address;
               end else begin
                  state_next = BEAT0;
               end
            end
         end
         BEAT0: begin
            memory_valid   = 1'b1;
            memory_read    = head.load;
            memory_write   = head.store;
            memory_byte_en = be_wide[NB-1:0];
            memory_address = aligned;
            memory_last    = !crossing;
            if (head.store)
               memory_data = data_wide[DW-1:0];
            if (memory_ready) begin
               if (crossing) begin
                  state_next = BEAT1;
               end else begin
                  deq        = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         BEAT1: begin
            memory_valid   = 1'b1;
            memory_read    = head.load;
            memory_write   = head.store;
            memory_byte_en = be_wide[2*NB-1:NB];
            memory_address = aligned + AB'(NB);
            memory_last    = 1'b1;
            if (head.store)
               memory_data = data_wide[2*DW-1:DW];
            if (memory_ready) begin
               deq        = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: doc/memory_issue_queue.md
MEMORY_ISSUE_QUEUE -- requirements
Module: memory_issue_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: memory data bus width in bits, a power of two and at least 16.
REQ-002 SHALL have parameter ADDRESS_BITS, default 20: byte address width.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4: request FIFO entries, a power of two and at least 2.
REQ-004 SHALL have parameter SPLIT_MISALIGNED, default 1: 1 splits line-crossing accesses into two beats; 0 rejects them with an error.
REQ-005 SHALL have local NUM_BYTES = DATA_WIDTH/8 and LOG2_NUM_BYTES = log2(NUM_BYTES).
REQ-006 One clock, reset asynchronous active-low; ports: clock in 1 rising-edge clock; reset in 1 asynchronous active-low reset.
REQ-007 SHALL have req_valid in 1, req_ready out 1: execute-side handshake.
REQ-008 SHALL have load in 1, store in 1, address in ADDRESS_BITS, store_data in DATA_WIDTH, log2_bytes in LOG2_NUM_BYTES+1: request fields, valid with req_valid.
REQ-009 SHALL have memory_valid out 1, memory_ready in 1: memory-side handshake.
REQ-010 SHALL have memory_read out 1, memory_write out 1, memory_byte_en out NUM_BYTES, memory_address out ADDRESS_BITS, memory_data out DATA_WIDTH, memory_last out 1: beat fields.
REQ-011 SHALL have issue_error out 1, error_address out ADDRESS_BITS, queue_count out log2(QUEUE_DEPTH)+1: rejected-request pulse, its address, and FIFO occupancy.

Function
REQ-012 Enqueue SHALL occur on the edge where req_valid and req_ready are both 1; req_ready = (queue_count < QUEUE_DEPTH), with no bypass when full.
REQ-013 Simultaneous enqueue and dequeue SHALL leave queue_count unchanged; pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-014 Issue FSM states SHALL be IDLE, BEAT0 and BEAT1.
- IDLE -> BEAT0 when the queue is non-empty and the head request is legal.
- BEAT0 -> BEAT1 on handshake when the request crosses a line.
- BEAT0 -> IDLE on handshake otherwise, with a dequeue.
- BEAT1 -> IDLE on handshake, with a dequeue.
REQ-015 Minimum latency SHALL be one cycle: a request accepted at edge N raises memory_valid after edge N+1.
REQ-016 Beat outputs SHALL be held stable while memory_valid=1 and memory_ready=0.
REQ-017 Definitions for beat generation:
- off = address[LOG2_NUM_BYTES-1:0]; size = 1<<log2_bytes; crossing = (off+size > NUM_BYTES).
- aligned = address with low LOG2_NUM_BYTES bits cleared.
REQ-018 BEAT0 SHALL drive memory_address = aligned, byte_en = (((1<<size)-1)<<off) truncated to NUM_BYTES, and data = (store_data<<8*off) truncated.
REQ-019 BEAT1 SHALL drive memory_address = aligned+NUM_BYTES (wrapping at 2^ADDRESS_BITS), byte_en = ((1<<size)-1)>>(NUM_BYTES-off), and data = store_data>>8*(NUM_BYTES-off).
REQ-020 memory_last SHALL be 1 on the final beat of each request.
REQ-021 memory_read/memory_write SHALL copy the head request's load/store on every beat; memory_data SHALL be 0 when store=0.
REQ-022 A head request with log2_bytes > LOG2_NUM_BYTES, with load=store=1, with load=store=0, or with crossing=1 while SPLIT_MISALIGNED=0 SHALL be dequeued without any beat, and SHALL raise issue_error for exactly one cycle with error_address = its address.
REQ-023 Outputs SHALL be combinational from FIFO head and FSM state only, with no path from req_* to memory_*.

Reset
REQ-024 While reset=0: queue_count=0, FSM=IDLE, and req_ready=0.
REQ-025 While reset=0, all of memory_valid, memory_read, memory_write, memory_byte_en, memory_address, memory_data, memory_last, issue_error and error_address SHALL be 0.
REQ-026 Reset asserted mid-request (including in BEAT1) SHALL discard all queued and in-flight requests.
REQ-027 req_ready SHALL rise in the first cycle after reset deasserts.

Verification (DATA_WIDTH=32, QUEUE_DEPTH=4)
REQ-028 Aligned word store: addr 0x100, data 0x11223344, log2_bytes=2, memory_ready=1 -> one beat with addr 0x100, be 1111, data 0x11223344, last=1.
REQ-029 Split halfword store: addr 0x103, data 0xABCD, log2_bytes=1 -> beat0 with addr 0x100, be 1000, data 0xCD000000, last=0; then beat1 with addr 0x104, be 0001, data 0x000000AB, last=1.
REQ-030 Split word store: addr 0x102, data 0x11223344, with memory_ready=0 for 3 cycles -> beat0 held stable with be 1100, data 0x33440000; then beat1 with be 0011, data 0x00001122.
REQ-031 Back-pressure: 5 back-to-back requests with memory_ready=0 -> req_ready=0 after 4 accepts and queue_count=4; one memory_ready pulse -> queue_count=3 and req_ready=1.
REQ-032 Errors: log2_bytes=3, or SPLIT_MISALIGNED=0 with a load at 0x1FF of log2_bytes=1 -> no memory_valid, one-cycle issue_error, error_address=request address.
REQ-033 Reset asserted in BEAT1 -> memory_valid=0 and queue_count=0 immediately, with no further beats after release.
